mcpu_control_fsm: RTL and testbench
===================================

// Module: mcpu_control_fsm
// PURPOSE
//  Multi-cycle MIPS control unit for MCPU: drives every datapath select line and write strobe.
//  Sits at the select end of the datapath two-/four-way muxes; one instruction = 3-5 states.
//  Memory accesses stall on a mem_ready handshake; unknown opcodes trap in ILLEGAL.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type (funct decoded in ALU control, alu_op=10)
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_ADDI   6'b001000  add immediate
//  OP_J      6'b000010  jump
//  OP_JAL    6'b000011  jump and link
// PORTS
//  clk            in   1  rising-edge clock
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  IR[31:26], valid from DECODE onward
//  mem_ready      in   1  memory done this cycle (read data valid / write accepted)
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (gated in datapath)
//  i_or_d         out  1  memory addr mux: 0=PC, 1=ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load
//  reg_dst        out  2  00=rt, 01=rd, 10=5'd31
//  mem_to_reg     out  2  00=ALUOut, 01=MDR, 10=PC
//  reg_write      out  1  register file write
//  alu_src_a      out  1  0=PC, 1=A
//  alu_src_b      out  2  00=B, 01=4, 10=signext(imm), 11=signext(imm)<<2
//  alu_op         out  2  00=add, 01=sub, 10=funct
//  pc_source      out  2  00=ALU result, 01=ALUOut, 10=jump target
//  state          out  4  current state (debug)
//  illegal        out  1  high while in ILLEGAL
// BEHAVIOUR
//  States (4-bit): 0 FETCH,1 DECODE,2 MEM_ADDR,3 MEM_READ,4 MEM_WB,5 MEM_WRITE,6 EXECUTE,
//   7 R_WB,8 BRANCH,9 JUMP,10 ADDI_EXEC,11 ADDI_WB,12 JAL,13 ILLEGAL; 14/15 -> FETCH next edge.
//  Reset: rst_n low -> state=FETCH immediately; all strobes (pc_write,pc_write_cond,ir_write,
//   reg_write,mem_write) forced 0 while rst_n low; all other outputs 0 except mem_read=1,
//   alu_src_b=01 (FETCH decode). Reset mid-instruction abandons it; no partial writes after.
//  Outputs: Moore decode of state, except strobes qualified by mem_ready where noted. Unlisted = 0.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//   ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next: LW/SW->MEM_ADDR, RTYPE->EXECUTE,
//   BEQ->BRANCH, ADDI->ADDI_EXEC, J->JUMP, JAL->JAL, else ILLEGAL.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW->MEM_READ, SW->MEM_WRITE.
//  MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
//  MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
//  MEM_WRITE: mem_write=1, i_or_d=1; hold (mem_write stays 1) until mem_ready -> FETCH.
//  EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB.
//  R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
//  ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
//  ADDI_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
//  JUMP: pc_write=1, pc_source=10 -> FETCH.
//  JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 -> FETCH
//   (PC already PC+4 from FETCH; written to $31 same edge PC loads target).
//  ILLEGAL: illegal=1, all strobes 0; held until reset.
//  Opcode sampled only in DECODE/MEM_ADDR; changes elsewhere ignored.
//  mem_ready ignored outside FETCH/MEM_READ/MEM_WRITE.
//  Cycle counts with mem_ready=1: LW 5, SW/R/ADDI 4, BEQ/J/JAL 3.
// TESTING
//  Reset release, mem_ready=1, opcode=RTYPE -> states 0,1,6,7,0; reg_write only in 7 with reg_dst=01.
//  LW with mem_ready low 2 cycles in FETCH and MEM_READ -> FETCH x3, MEM_READ x3; ir_write 1 cycle only.
//  BEQ -> 0,1,8,0; in 8: pc_write_cond=1, alu_op=01, pc_source=01, pc_write=0.
//  JAL -> 0,1,12; in 12: pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, pc_source=10.
//  opcode=6'b111111 -> ILLEGAL, illegal=1, no strobes for 20 cycles; rst_n low -> FETCH async.
//  SW with rst_n pulsed low mid MEM_WRITE -> mem_write drops same cycle, state=FETCH, no later write.

Source files
------------

// File: rtl/mcpu_control_fsm_if.sv
// Control bundle between the MCPU control FSM and the multi-cycle datapath.
// Latency: none, plain wires.
// Backpressure: memory stalls are signalled back through mem_ready.
//
// Signals:
//   opcode, mem_ready        datapath -> control (IR[31:26], memory done)
//   pc_write, pc_write_cond  PC load strobes
//   i_or_d, mem_read,        memory address select and request strobes
//   mem_write
//   ir_write, reg_write      IR and register file load strobes
//   reg_dst, mem_to_reg      register file write address / data selects
//   alu_src_a, alu_src_b,    ALU operand selects and operation class
//   alu_op
//   pc_source                next-PC select
//   state, illegal           debug view of the FSM and the trap flag
interface mcpu_control_fsm_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;

    // control unit side
    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal
    );

    // datapath side
    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal
    );
endinterface

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle MIPS control unit: Moore decode of the current state drives every datapath select/strobe.
// Latency: 3-5 states per instruction (LW 5, SW/R/ADDI 4, BEQ/J/JAL 3) when memory is ready at once.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold until mem_ready; unknown opcodes trap in ILLEGAL.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; strobes are forced low while it is asserted
//   ctl    mcpu_control_fsm_if.master: opcode/mem_ready in, all control lines, state and illegal out
module mcpu_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_JAL   = 6'b000011
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mcpu_control_fsm_if.master     ctl
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_JAL       = 4'd12;
    localparam logic [3:0] S_ILLEGAL   = 4'd13;

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Opcode only matters in DECODE and MEM_ADDR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = ctl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (ctl.opcode == OP_LW || ctl.opcode == OP_SW) state_d = S_MEM_ADDR;
                else if (ctl.opcode == OP_RTYPE)                state_d = S_EXECUTE;
                else if (ctl.opcode == OP_BEQ)                  state_d = S_BRANCH;
                else if (ctl.opcode == OP_ADDI)                 state_d = S_ADDI_EXEC;
                else if (ctl.opcode == OP_J)                    state_d = S_JUMP;
                else if (ctl.opcode == OP_JAL)                  state_d = S_JAL;
                else                                            state_d = S_ILLEGAL;
            end
            // Only LW/SW reach MEM_ADDR; anything else here means IR was corrupted, so trap.
            S_MEM_ADDR: begin
                if (ctl.opcode == OP_LW)      state_d = S_MEM_READ;
                else if (ctl.opcode == OP_SW) state_d = S_MEM_WRITE;
                else                          state_d = S_ILLEGAL;
            end
            S_MEM_READ:  state_d = ctl.mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = ctl.mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_FETCH;   // unused encodings 14/15 recover
        endcase
    end

    // Output decode; strobes are collected separately so reset can mask them.
    logic       pc_write_s;
    logic       pc_write_cond_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic [1:0] reg_dst_c;
    logic [1:0] mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] pc_source_c;

    always_comb begin
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        mem_write_s     = 1'b0;
        ir_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        reg_dst_c       = 2'b00;
        mem_to_reg_c    = 2'b00;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        pc_source_c     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                // IR and PC+4 load together on the cycle the instruction word arrives
                ir_write_s  = ctl.mem_ready;
                pc_write_s  = ctl.mem_ready;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;   // precompute branch target
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            S_MEM_READ: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_c = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                i_or_d_c    = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
            end
            S_R_WB: begin
                reg_write_s = 1'b1;
                reg_dst_c   = 2'b01;
            end
            S_BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = 2'b01;
                pc_write_cond_s = 1'b1;
                pc_source_c     = 2'b01;
            end
            S_JUMP: begin
                pc_write_s  = 1'b1;
                pc_source_c = 2'b10;
            end
            S_ADDI_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write_s = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH; it goes to $31 on the same edge PC takes the target
                pc_write_s   = 1'b1;
                pc_source_c  = 2'b10;
                reg_write_s  = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
            end
            default: ;
        endcase
    end

    // Async reset already forces state to FETCH; masking the strobes with rst_n keeps
    // FETCH's mem_ready-driven loads from firing while reset is held.
    assign ctl.pc_write      = pc_write_s      & rst_n;
    assign ctl.pc_write_cond = pc_write_cond_s & rst_n;
    assign ctl.mem_write     = mem_write_s     & rst_n;
    assign ctl.ir_write      = ir_write_s      & rst_n;
    assign ctl.reg_write     = reg_write_s     & rst_n;
    assign ctl.i_or_d        = i_or_d_c;
    assign ctl.mem_read      = mem_read_c;
    assign ctl.reg_dst       = reg_dst_c;
    assign ctl.mem_to_reg    = mem_to_reg_c;
    assign ctl.alu_src_a     = alu_src_a_c;
    assign ctl.alu_src_b     = alu_src_b_c;
    assign ctl.alu_op        = alu_op_c;
    assign ctl.pc_source     = pc_source_c;
    assign ctl.state         = state_q;
    assign ctl.illegal       = (state_q == S_ILLEGAL);

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Testbench for mcpu_control_fsm: random instruction stream with random memory stalls, scoreboarded.
// Latency: expected control word per cycle is queued by the driver and popped by the monitor at negedge.
// Backpressure: mem_ready stalls are generated per instruction; reset is pulsed mid-store and in ILLEGAL.
module tb_mcpu_control_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [3:0] state;
        logic       illegal;
    } ctrl_t;

    logic clk;
    logic rst_n;
    mcpu_control_fsm_if bus ();

    mcpu_control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    checks;
    int    errors;
    ctrl_t exp_q[$];

    // Reference model: current step name (spec numbering), remaining path of the instruction.
    int model_state;
    int path[$];
    int wait_cnt;
    int cyc;

    function automatic bit is_wait(input int st);
        return (st == 0 || st == 3 || st == 5);
    endfunction

    // Control word the spec lists for each step.
    function automatic ctrl_t exp_word(input int st, input bit mr, input bit rn);
        ctrl_t e;
        e = '0;
        e.state = 4'(st);
        case (st)
            0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            1:  e.alu_src_b = 2'b11;
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.i_or_d = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            5:  begin e.mem_write = 1; e.i_or_d = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            7:  begin e.reg_write = 1; e.reg_dst = 2'b01; end
            8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            9:  begin e.pc_write = 1; e.pc_source = 2'b10; end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            11: e.reg_write = 1;
            12: begin e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1;
                      e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
            13: e.illegal = 1;
            default: ;
        endcase
        if (!rn) begin
            e.pc_write = 0; e.pc_write_cond = 0; e.ir_write = 0; e.reg_write = 0; e.mem_write = 0;
        end
        return e;
    endfunction

    // Advance the model by one clock edge given the inputs that were present at it.
    task automatic model_step(input logic [5:0] op, input bit mr);
        if (model_state == 13) return;
        if (is_wait(model_state) && !mr) return;
        if (model_state == 0) begin
            model_state = 1;
            return;
        end
        if (model_state == 1) begin
            path.delete();
            case (op)
                OP_LW:    path = '{2, 3, 4};
                OP_SW:    path = '{2, 5};
                OP_RTYPE: path = '{6, 7};
                OP_BEQ:   path = '{8};
                OP_ADDI:  path = '{10, 11};
                OP_J:     path = '{9};
                OP_JAL:   path = '{12};
                default:  path = '{13};
            endcase
        end
        if (path.size() > 0) model_state = path.pop_front();
        else                 model_state = 0;
    endtask

    task automatic tick();
        bit rn_at_edge;
        @(posedge clk);
        rn_at_edge = rst_n;
        #1;
        if (rn_at_edge) model_step(bus.opcode, bus.mem_ready);
        cyc++;
    endtask

    // Drive one cycle of inputs and queue the expected outputs for it.
    task automatic drive(input logic [5:0] op, input int stalls, input bit rst_in_store);
        bit mr;
        if (model_state == 1 || model_state == 2) bus.opcode = op;
        else                                      bus.opcode = 6'($urandom);
        if (is_wait(model_state)) begin
            if (wait_cnt < stalls) begin
                mr = 0;
                wait_cnt++;
            end else begin
                mr = 1;
                wait_cnt = 0;
            end
        end else begin
            mr = 1'($urandom);
            wait_cnt = 0;
        end
        if (rst_in_store && model_state == 5 && wait_cnt == 2) begin
            // second stalled MEM_WRITE cycle: pull reset between clock edges
            mr = 0;
            bus.mem_ready = mr;
            rst_n = 0;
            model_state = 0;
            path.delete();
            wait_cnt = 0;
            exp_q.push_back(exp_word(0, mr, 0));
            #5 rst_n = 1;
        end else begin
            bus.mem_ready = mr;
            exp_q.push_back(exp_word(model_state, mr, rst_n));
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int stalls, input bit rst_in_store);
        bit started;
        bit done;
        started = 0;
        done = 0;
        wait_cnt = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            drive(op, stalls, rst_in_store);
            tick();
            if (model_state != 0) started = 1;
            else if (started)     done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL instr_timeout op=%b model_state=%0d dut_state=%0d required=back_to_fetch",
                     op, model_state, bus.state);
        end
    endtask

    // Monitor: one expected word per driven cycle.
    initial begin
        ctrl_t act;
        ctrl_t exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = '{bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                        bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                        bus.alu_src_b, bus.alu_op, bus.pc_source, bus.state, bus.illegal};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL ctrl_word cyc=%0d rst_n=%b mem_ready=%b actual=%h(state %0d) required=%h(state %0d)",
                             cyc, rst_n, bus.mem_ready, act, act.state, exp, exp.state);
                end
            end
        end
    end

    logic [5:0] legal_ops [7];

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        model_state = 0;
        wait_cnt = 0;
        legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};

        // Reset held: FETCH decode with strobes masked, even with mem_ready high.
        rst_n = 0;
        bus.opcode = OP_RTYPE;
        bus.mem_ready = 0;
        #1 exp_q.push_back(exp_word(0, 0, 0));
        @(negedge clk);
        #1;
        bus.mem_ready = 1;
        exp_q.push_back(exp_word(0, 1, 0));
        @(negedge clk);
        #1;
        bus.mem_ready = 0;
        rst_n = 1;
        tick();

        // Directed sequences
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 2, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(OP_SW, 3, 1);     // reset lands in MEM_WRITE
        run_instr(OP_ADDI, 1, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_SW, 1, 0);

        // Random legal instruction stream
        for (int i = 0; i < 150; i++) begin
            run_instr(legal_ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)), 0);
        end

        // Illegal opcode: trap and stay put for well over 20 cycles
        wait_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            drive(OP_BAD, 1, 0);
            tick();
        end
        checks++;
        if (model_state != 13 || bus.illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_trap actual_state=%0d illegal=%b required_state=13 illegal=1",
                     bus.state, bus.illegal);
        end

        // Async reset out of ILLEGAL, sampled before any clock edge
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL async_reset actual_state=%0d illegal=%b required_state=0 illegal=0",
                     bus.state, bus.illegal);
        end
        model_state = 0;
        path.delete();
        bus.mem_ready = 0;
        #1 rst_n = 1;
        tick();
        run_instr(OP_LW, 0, 0);
        run_instr(OP_RTYPE, 1, 0);

        for (int c = 0; c < 5 && exp_q.size() > 0; c++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
